// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game blocks.
// Contents:
//   game_state_t    - game-level state driven by game_controller
//   pipe_x_t        - pipe horizontal position (10 bits)
//   pipe_y_t        - pipe gap vertical position (9 bits)
//   scroll_state_t  - pipe_scroller internal FSM states
//   LFSR_MASK       - Galois feedback mask shared by every LFSR user
//   DEF_*           - default screen geometry, also used by game_controller
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PLAY      = 2'b01,
        GAME_OVER = 2'b10
    } game_state_t;

    typedef enum logic [1:0] {
        S_PARK = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } scroll_state_t;

    typedef logic [9:0] pipe_x_t;
    typedef logic [8:0] pipe_y_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam int          DEF_SCREEN_WIDTH  = 640;
    localparam int          DEF_SCREEN_HEIGHT = 480;
    localparam int          DEF_PIPE_WIDTH    = 50;
    localparam int          DEF_PIPE_GAP      = 100;
    localparam int          DEF_BIRD_X        = 500;
    localparam int          DEF_SCROLL_SPEED  = 2;
    localparam int          DEF_GAP_MARGIN    = 40;
    localparam logic [15:0] DEF_LFSR_SEED     = 16'hACE1;

endpackage

// File: rtl/pipe_scroller_if.sv
// Pipe stream bundle between game_controller (master) and pipe_scroller (slave).
// Signals:
//   frame_tick  - one-cycle pulse per video frame
//   game_state  - 00 IDLE, 01 PLAY, 10 GAME_OVER, 11 treated as IDLE
//   pipe_x      - pipe left edge; SCREEN_WIDTH means parked off-screen right
//   pipe_gap_y  - top Y of the pipe gap
//   score_pulse - one-cycle pulse each time the pipe clears the bird
//   score       - passed-pipe count, saturating at 255
interface pipe_scroller_if;
    import flappy_pkg::*;

    logic       frame_tick;
    logic [1:0] game_state;
    pipe_x_t    pipe_x;
    pipe_y_t    pipe_gap_y;
    logic       score_pulse;
    logic [7:0] score;

    modport master (
        output frame_tick,
        output game_state,
        input  pipe_x,
        input  pipe_gap_y,
        input  score_pulse,
        input  score
    );

    modport slave (
        input  frame_tick,
        input  game_state,
        output pipe_x,
        output pipe_gap_y,
        output score_pulse,
        output score
    );

endinterface

// File: rtl/pipe_scroller_lfsr.sv
// pipe_lfsr: free-running 16-bit Galois LFSR (right shift), reusable by any
// block that needs cheap pseudo-randomness.
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high; loads SEED
//   lfsr_out - current LFSR register value
module pipe_lfsr
    import flappy_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED,
    parameter logic [15:0] MASK = LFSR_MASK
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr_out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls the single active pipe leftwards on each frame tick
// during PLAY, respawns it at the right edge with a pseudo-random gap, emits a
// score pulse when the pipe's trailing edge crosses the bird, freezes on
// GAME_OVER and re-parks on IDLE.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - pipe_scroller_if.slave (frame_tick/game_state in, pipe stream out)
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_PARK | pipe parked at SCREEN_WIDTH, waiting for PLAY
// S_RUN  | pipe scrolls on frame ticks, respawns, scores
// S_HALT | game over: pipe frozen, only IDLE (or 11) returns to S_PARK
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int          SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int          PIPE_WIDTH    = DEF_PIPE_WIDTH,
    parameter int          PIPE_GAP      = DEF_PIPE_GAP,
    parameter int          BIRD_X        = DEF_BIRD_X,
    parameter int          SCROLL_SPEED  = DEF_SCROLL_SPEED,
    parameter int          GAP_MARGIN    = DEF_GAP_MARGIN,
    parameter logic [15:0] LFSR_SEED     = DEF_LFSR_SEED
) (
    input  logic            clk,
    input  logic            reset,
    pipe_scroller_if.slave  bus
);

    localparam int GAP_RANGE = SCREEN_HEIGHT - PIPE_GAP - 2 * GAP_MARGIN;

    if (LFSR_SEED == 16'h0000) begin : g_chk_seed
        $error("pipe_scroller: LFSR_SEED must be non-zero");
    end
    // A 9-bit draw needs at most one subtract only if the range exceeds 256.
    if (GAP_RANGE <= 256) begin : g_chk_range
        $error("pipe_scroller: gap range must exceed 256");
    end
    if (SCREEN_WIDTH > 1023) begin : g_chk_width
        $error("pipe_scroller: SCREEN_WIDTH must fit in 10 bits");
    end
    if (BIRD_X >= SCREEN_WIDTH) begin : g_chk_bird
        $error("pipe_scroller: BIRD_X must be left of the spawn edge");
    end
    if (SCROLL_SPEED < 1) begin : g_chk_speed
        $error("pipe_scroller: SCROLL_SPEED must be at least 1");
    end

    function automatic pipe_y_t gap_of(input logic [15:0] lfsr);
        logic [9:0] r;
        r = {1'b0, lfsr[8:0]};
        if (r >= 10'(GAP_RANGE)) begin
            r = r - 10'(GAP_RANGE);
        end
        return pipe_y_t'(10'(GAP_MARGIN) + r);
    endfunction

    logic [15:0]   lfsr_w;

    scroll_state_t state_q, state_d;
    pipe_x_t       pipe_x_q, pipe_x_d;
    pipe_y_t       gap_q, gap_d;
    logic [7:0]    score_q, score_d;
    logic          pulse_q, pulse_d;

    logic [10:0]   lead_sum;
    logic [10:0]   trail_sum;

    pipe_lfsr #(
        .SEED (LFSR_SEED),
        .MASK (LFSR_MASK)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .lfsr_out (lfsr_w)
    );

    // Trailing edge of the pipe before and after this move, at 11 bits so the
    // sum cannot wrap at the right screen edge.
    assign lead_sum  = {1'b0, pipe_x_q} + 11'(PIPE_WIDTH);
    assign trail_sum = lead_sum - 11'(SCROLL_SPEED);

    always_comb begin
        state_d  = state_q;
        pipe_x_d = pipe_x_q;
        gap_d    = gap_q;
        score_d  = score_q;
        pulse_d  = 1'b0;

        case (state_q)
            S_PARK: begin
                if (bus.game_state == PLAY) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.game_state == GAME_OVER) begin
                    state_d = S_HALT;
                end else if (bus.game_state != PLAY) begin
                    state_d = S_PARK;
                end
            end
            S_HALT: begin
                if (bus.game_state == IDLE || bus.game_state == 2'b11) begin
                    state_d = S_PARK;
                end
            end
            default: begin
                state_d = S_PARK;
            end
        endcase

        // Movement keys off the registered state so a tick on the
        // PARK->RUN edge is dropped and a tick on the RUN->HALT edge counts.
        if (state_q == S_RUN && bus.frame_tick) begin
            if (pipe_x_q < pipe_x_t'(SCROLL_SPEED)) begin
                pipe_x_d = pipe_x_t'(SCREEN_WIDTH);
                gap_d    = gap_of(lfsr_w);
            end else begin
                pipe_x_d = pipe_x_q - pipe_x_t'(SCROLL_SPEED);
                if (lead_sum >= 11'(BIRD_X) && trail_sum < 11'(BIRD_X)) begin
                    pulse_d = 1'b1;
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                end
            end
        end

        // Re-parking takes priority over any move on the same edge.
        if (state_q != S_PARK && state_d == S_PARK) begin
            pipe_x_d = pipe_x_t'(SCREEN_WIDTH);
            gap_d    = gap_of(lfsr_w);
            score_d  = 8'd0;
            pulse_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_PARK;
            pipe_x_q <= pipe_x_t'(SCREEN_WIDTH);
            gap_q    <= gap_of(LFSR_SEED);
            score_q  <= 8'd0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pipe_x_q <= pipe_x_d;
            gap_q    <= gap_d;
            score_q  <= score_d;
            pulse_q  <= pulse_d;
        end
    end

    assign bus.pipe_x      = pipe_x_q;
    assign bus.pipe_gap_y  = gap_q;
    assign bus.score       = score_q;
    assign bus.score_pulse = pulse_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed testbench for pipe_scroller at default parameters.
module tb_pipe_scroller;

    logic        clk;
    logic        reset;
    logic [15:0] m_lfsr;
    logic [15:0] snap;
    int          n_tests;
    int          n_fail;

    pipe_scroller_if bus ();

    pipe_scroller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: Galois, right shift, mask B400, seed ACE1.
    always @(posedge clk) begin
        if (reset) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    function automatic int exp_gap(input logic [15:0] l);
        int r;
        r = int'(l[8:0]);
        if (r >= 300) r = r - 300;
        return 40 + r;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // One frame tick; snap holds the LFSR value the DUT sees on that edge.
    task automatic do_tick();
        snap = m_lfsr;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        int pulses;
        int pulse_at;
        logic [8:0] held_gap;

        n_tests = 0;
        n_fail  = 0;
        snap    = 16'h0;
        bus.frame_tick = 1'b0;
        bus.game_state = 2'b00;
        reset = 1'b1;
        repeat (2) cyc();

        check("rst_pipe_x", 32'(bus.pipe_x), 640);
        check("rst_gap", 32'(bus.pipe_gap_y), 265);
        check("rst_score", 32'(bus.score), 0);
        check("rst_pulse", 32'(bus.score_pulse), 0);
        reset = 1'b0;

        // PLAY without ticks leaves the pipe parked.
        bus.game_state = 2'b01;
        repeat (5) cyc();
        check("play_no_tick_x", 32'(bus.pipe_x), 640);
        bus.game_state = 2'b00;
        cyc();
        check("idle_x", 32'(bus.pipe_x), 640);

        // Tick on the PARK->RUN edge is dropped; the next one moves.
        bus.game_state = 2'b01;
        do_tick();
        check("coinc_tick_x", 32'(bus.pipe_x), 640);
        do_tick();
        check("next_tick_x", 32'(bus.pipe_x), 638);

        // Encoding 11 behaves as IDLE.
        bus.game_state = 2'b11;
        snap = m_lfsr;
        cyc();
        check("park11_x", 32'(bus.pipe_x), 640);
        check("park11_gap", 32'(bus.pipe_gap_y), 32'(exp_gap(snap)));
        check("park11_score", 32'(bus.score), 0);

        // Long run: 256 laps of 321 ticks, one pass per lap at tick 96.
        bus.game_state = 2'b01;
        cyc();
        for (int lap = 1; lap <= 256; lap++) begin
            pulses   = 0;
            pulse_at = 0;
            for (int t = 1; t <= 321; t++) begin
                do_tick();
                if (bus.score_pulse) begin
                    pulses++;
                    pulse_at = t;
                end
                if (lap == 1 && t == 96) begin
                    check("lap1_t96_x", 32'(bus.pipe_x), 448);
                    check("lap1_t96_score", 32'(bus.score), 1);
                end
                if (t == 320) begin
                    check("t320_x", 32'(bus.pipe_x), 0);
                end
                if (t == 321) begin
                    check("respawn_x", 32'(bus.pipe_x), 640);
                    check("respawn_gap", 32'(bus.pipe_gap_y), 32'(exp_gap(snap)));
                    check("respawn_gap_range",
                          32'((bus.pipe_gap_y >= 9'd40) && (bus.pipe_gap_y <= 9'd340)), 1);
                end
            end
            check("lap_pulse_count", 32'(pulses), 1);
            check("lap_pulse_tick", 32'(pulse_at), 96);
            check("lap_score", 32'(bus.score), 32'((lap > 255) ? 255 : lap));
        end

        // GAME_OVER freezes the pipe; PLAY is ignored until IDLE.
        repeat (50) do_tick();
        check("pre_halt_x", 32'(bus.pipe_x), 540);
        held_gap = bus.pipe_gap_y;
        bus.game_state = 2'b10;
        cyc();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            if (bus.score_pulse) pulses++;
        end
        check("halt_x", 32'(bus.pipe_x), 540);
        check("halt_gap", 32'(bus.pipe_gap_y), 32'(held_gap));
        check("halt_score", 32'(bus.score), 255);
        check("halt_pulses", 32'(pulses), 0);
        bus.game_state = 2'b01;
        repeat (5) do_tick();
        check("halt_play_x", 32'(bus.pipe_x), 540);
        bus.game_state = 2'b00;
        snap = m_lfsr;
        cyc();
        check("unhalt_x", 32'(bus.pipe_x), 640);
        check("unhalt_score", 32'(bus.score), 0);
        check("unhalt_gap", 32'(bus.pipe_gap_y), 32'(exp_gap(snap)));

        // Reset coincident with a scoring tick.
        bus.game_state = 2'b01;
        cyc();
        repeat (416) do_tick();
        check("pre_rst_x", 32'(bus.pipe_x), 450);
        check("pre_rst_score", 32'(bus.score), 1);
        reset = 1'b1;
        do_tick();
        check("midrst_x", 32'(bus.pipe_x), 640);
        check("midrst_gap", 32'(bus.pipe_gap_y), 265);
        check("midrst_score", 32'(bus.score), 0);
        check("midrst_pulse", 32'(bus.score_pulse), 0);
        reset = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
